// File: rtl/cmp_zelg_serial_pkg.sv
// Shared definitions for the serial zero/equal/less/greater comparator:
// FSM encodings, the flag bundle and an index-width helper.
package cmp_zelg_serial_pkg;

  localparam logic [1:0] CMPS_IDLE = 2'd0;
  localparam logic [1:0] CMPS_RUN  = 2'd1;
  localparam logic [1:0] CMPS_DONE = 2'd2;

  typedef struct packed {
    logic zero;
    logic equal;
    logic less;
    logic greater;
  } cmp_flags_t;

  // A chunk index needs at least one bit, even when there is only one chunk.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/cmp_zelg_serial_cmp.sv
// Combinational unsigned zero/equal/less/greater compare of one chunk.
module cmp_zelg_serial_cmp
  import cmp_zelg_serial_pkg::*;
#(
  parameter int p_WIDTH = 8
) (
  input  logic [p_WIDTH-1:0] iv_x,
  input  logic [p_WIDTH-1:0] iv_y,
  output cmp_flags_t         o_flags
);

  always_comb begin
    o_flags         = '0;
    o_flags.zero    = (iv_x == '0) && (iv_y == '0);
    o_flags.equal   = (iv_x == iv_y);
    o_flags.less    = (iv_x < iv_y);
    o_flags.greater = (iv_x > iv_y);
  end

endmodule

// File: rtl/cmp_zelg_serial.sv
// Multi-cycle magnitude comparator: one chunk per cycle, MSB chunk first,
// stopping at the first chunk that differs. Signed mode is chosen per request.
module cmp_zelg_serial
  import cmp_zelg_serial_pkg::*;
#(
  parameter int p_WIDTH = 32,
  parameter int p_CHUNK = 8
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [p_WIDTH-1:0]                    iv_x,
  input  logic [p_WIDTH-1:0]                    iv_y,
  input  logic                                  i_signed,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic                                  o_zero,
  output logic                                  o_equal,
  output logic                                  o_less,
  output logic                                  o_greater,
  output logic [$clog2(p_WIDTH/p_CHUNK+1)-1:0]  ov_chunks
);

  localparam int NCHUNK = p_WIDTH / p_CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] TOP_IDX = IW'(NCHUNK - 1);

  if ((p_CHUNK < 1) || (p_CHUNK > p_WIDTH) || ((p_WIDTH % p_CHUNK) != 0)) begin : g_width_check
    $error("cmp_zelg_serial: p_WIDTH must be a positive multiple of p_CHUNK");
  end

  logic [1:0]         state_reg;
  logic               ready_reg;
  logic [p_WIDTH-1:0] x_reg;
  logic [p_WIDTH-1:0] y_reg;
  logic               signed_reg;
  logic [IW-1:0]      idx_reg;
  logic               zero_run_reg;
  cmp_flags_t         flags_reg;
  logic [CW-1:0]      chunks_reg;

  logic [p_CHUNK-1:0] x_chunks [NCHUNK];
  logic [p_CHUNK-1:0] y_chunks [NCHUNK];
  logic [p_CHUNK-1:0] x_raw;
  logic [p_CHUNK-1:0] y_raw;
  logic [p_CHUNK-1:0] flip_mask;
  logic               msb_flip;
  logic               chunk_zero;
  cmp_flags_t         chunk_flags;

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    assign x_chunks[gi] = x_reg[gi*p_CHUNK +: p_CHUNK];
    assign y_chunks[gi] = y_reg[gi*p_CHUNK +: p_CHUNK];
  end

  if (NCHUNK == 1) begin : g_mux_single
    assign x_raw = x_chunks[0];
    assign y_raw = y_chunks[0];
  end else begin : g_mux_multi
    assign x_raw = x_chunks[idx_reg];
    assign y_raw = y_chunks[idx_reg];
  end

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  assign msb_flip = signed_reg && (idx_reg == TOP_IDX);

  always_comb begin
    flip_mask            = '0;
    flip_mask[p_CHUNK-1] = msb_flip;
  end

  cmp_zelg_serial_cmp #(.p_WIDTH(p_CHUNK)) u_cmp (
    .iv_x    (x_raw ^ flip_mask),
    .iv_y    (y_raw ^ flip_mask),
    .o_flags (chunk_flags)
  );

  // The compare's zero flag sees the flipped chunk, so use the raw chunk there.
  assign chunk_zero = msb_flip ? (x_raw == '0) : chunk_flags.zero;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= CMPS_IDLE;
      ready_reg    <= 1'b0;
      x_reg        <= '0;
      y_reg        <= '0;
      signed_reg   <= 1'b0;
      idx_reg      <= '0;
      zero_run_reg <= 1'b0;
      flags_reg    <= '0;
      chunks_reg   <= '0;
    end else begin
      case (state_reg)
        CMPS_IDLE: begin
          ready_reg <= 1'b1;
          if (ready_reg && i_valid) begin
            x_reg        <= iv_x;
            y_reg        <= iv_y;
            signed_reg   <= i_signed;
            idx_reg      <= TOP_IDX;
            zero_run_reg <= 1'b1;
            ready_reg    <= 1'b0;
            state_reg    <= CMPS_RUN;
          end
        end
        CMPS_RUN: begin
          if (!chunk_flags.equal) begin
            flags_reg.zero    <= 1'b0;
            flags_reg.equal   <= 1'b0;
            flags_reg.less    <= chunk_flags.less;
            flags_reg.greater <= chunk_flags.greater;
            chunks_reg        <= CW'(NCHUNK) - CW'(idx_reg);
            state_reg         <= CMPS_DONE;
          end else if (idx_reg == '0) begin
            flags_reg.zero    <= zero_run_reg & chunk_zero;
            flags_reg.equal   <= 1'b1;
            flags_reg.less    <= 1'b0;
            flags_reg.greater <= 1'b0;
            chunks_reg        <= CW'(NCHUNK);
            state_reg         <= CMPS_DONE;
          end else begin
            idx_reg      <= idx_reg - 1'b1;
            zero_run_reg <= zero_run_reg & chunk_zero;
          end
        end
        CMPS_DONE: begin
          if (i_ready) begin
            ready_reg <= 1'b1;
            state_reg <= CMPS_IDLE;
          end
        end
        default: begin
          state_reg <= CMPS_IDLE;
        end
      endcase
    end
  end

  assign o_ready   = ready_reg;
  assign o_valid   = (state_reg == CMPS_DONE);
  assign o_zero    = flags_reg.zero;
  assign o_equal   = flags_reg.equal;
  assign o_less    = flags_reg.less;
  assign o_greater = flags_reg.greater;
  assign ov_chunks = chunks_reg;

endmodule
